// File: rtl/usb_clk_reset_seq.sv
// PLL lock qualification, USB core reset sequencing, 12 MHz bit enable and 1 ms frame tick.
// Optional saturating lock-loss counter on port loss_count when USB_LOCK_LOSS_CNT_EN is defined.
module usb_clk_reset_seq #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RST_HOLD_CYCLES    = 16,
  parameter int CLK_DIV            = 2,
  parameter int MS_DIV             = 24000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_lock,
  input  logic       lock_lost_clr,
  output logic       usb_rst,
  output logic       usb_ce,
  output logic       ms_tick,
  output logic       ready,
`ifdef USB_LOCK_LOSS_CNT_EN
  output logic       lock_lost,
  output logic [7:0] loss_count
`else
  output logic       lock_lost
`endif
);

  localparam int STAB_W = $clog2(LOCK_STABLE_CYCLES);
  localparam int HOLD_W = $clog2(RST_HOLD_CYCLES);
  localparam int CNT_W  = (STAB_W > HOLD_W) ? STAB_W : HOLD_W;
  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int MS_W   = $clog2(MS_DIV);

  localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [MS_W-1:0]  MS_LAST   = MS_W'(MS_DIV - 1);

  typedef enum logic [2:0] {
    WAIT_LOCK,
    STABLE,
    HOLD,
    RUN,
    LOST
  } state_t;

  state_t           state;
  logic             lock_meta;
  logic             lock_s;
  logic [CNT_W-1:0] cnt;
  logic [DIV_W-1:0] div_cnt;
  logic [MS_W-1:0]  ms_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= WAIT_LOCK;
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
      cnt       <= '0;
      div_cnt   <= '0;
      ms_cnt    <= '0;
      usb_rst   <= 1'b1;
      usb_ce    <= 1'b0;
      ms_tick   <= 1'b0;
      ready     <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
      usb_ce    <= 1'b0;
      ms_tick   <= 1'b0;
      if (lock_lost_clr)
        lock_lost <= 1'b0;

      case (state)
        WAIT_LOCK: begin
          usb_rst <= 1'b1;
          cnt     <= '0;
          if (lock_s)
            state <= STABLE;
        end

        STABLE: begin
          if (!lock_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == STAB_LAST) begin
            state <= HOLD;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        HOLD: begin
          if (!lock_s) begin
            state <= LOST;
          end else begin
            if (div_cnt == DIV_LAST) begin
              div_cnt <= '0;
              usb_ce  <= 1'b1;
            end else begin
              div_cnt <= div_cnt + DIV_W'(1);
            end
            if (cnt == HOLD_LAST) begin
              state   <= RUN;
              cnt     <= '0;
              usb_rst <= 1'b0;
              ready   <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end

        RUN: begin
          // The RUN->LOST edge leaves usb_rst/ready alone; LOST applies them one edge later.
          if (!lock_s) begin
            state <= LOST;
          end else begin
            if (div_cnt == DIV_LAST) begin
              div_cnt <= '0;
              usb_ce  <= 1'b1;
            end else begin
              div_cnt <= div_cnt + DIV_W'(1);
            end
            if (ms_cnt == MS_LAST) begin
              ms_cnt  <= '0;
              ms_tick <= 1'b1;
            end else begin
              ms_cnt <= ms_cnt + MS_W'(1);
            end
          end
        end

        LOST: begin
          state     <= WAIT_LOCK;
          usb_rst   <= 1'b1;
          ready     <= 1'b0;
          lock_lost <= 1'b1;
          cnt       <= '0;
          div_cnt   <= '0;
          ms_cnt    <= '0;
        end

        default: begin
          state   <= WAIT_LOCK;
          usb_rst <= 1'b1;
          ready   <= 1'b0;
          cnt     <= '0;
          div_cnt <= '0;
          ms_cnt  <= '0;
        end
      endcase
    end
  end

`ifdef USB_LOCK_LOSS_CNT_EN
  // A loss in the same cycle as a clear still counts.
  always_ff @(posedge clk) begin
    if (reset) begin
      loss_count <= 8'd0;
    end else if (state == LOST) begin
      if (loss_count != 8'hFF)
        loss_count <= loss_count + 8'd1;
    end else if (lock_lost_clr) begin
      loss_count <= 8'd0;
    end
  end
`endif

endmodule
